// File: rtl/seg_sched_pkg.sv
// Shared types and constants for the 7-segment display scheduler.
// Used by seg_tick_prescaler and seg_display_scheduler.
package seg_sched_pkg;

  typedef enum logic [1:0] {
    SHOW_A = 2'd0,
    SHOW_B = 2'd1,
    ALERT  = 2'd2
  } sched_state_t;

  localparam logic [1:0]  ACTIVE_SRC_A     = 2'd0;
  localparam logic [1:0]  ACTIVE_SRC_B     = 2'd1;
  localparam logic [1:0]  ACTIVE_SRC_ALERT = 2'd2;
  localparam logic [15:0] BLANK_CODE       = 16'hFFFF;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_tick_prescaler.sv
// Divides clk by TICK_DIV and emits a one-cycle tick on the terminal count.
// A synchronous clear restarts the count from zero.
module seg_tick_prescaler
  import seg_sched_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = cnt_width(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/seg_display_scheduler.sv
// Time-shares a 4-digit display between two BCD sources and a handshaked alert.
// Define SEG_BLINK_EN to blink the alert code against BLANK_CODE every tick.
module seg_display_scheduler
  import seg_sched_pkg::*;
#(
  parameter int TICK_DIV     = 50_000_000,
  parameter int ROTATE_TICKS = 3,
  parameter int ALERT_TICKS  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] src_a_code,
  input  logic [15:0] src_b_code,
  input  logic        alert_valid,
  input  logic [15:0] alert_code,
  output logic        alert_ready,
  output logic [15:0] seg_8421_code,
  output logic [1:0]  active_src
);

  localparam int MAX_TICKS = (ROTATE_TICKS > ALERT_TICKS) ? ROTATE_TICKS : ALERT_TICKS;
  localparam int DW = cnt_width(MAX_TICKS);

  sched_state_t  state, next_state, saved_state;
  logic [DW-1:0] dwell, dwell_limit;
  logic [15:0]   alert_latch;
  logic          tick, expire, accept, transition;

  seg_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (transition),
    .tick  (tick)
  );

  // An accepted alert beats a simultaneous dwell expiry.
  always_comb begin
    dwell_limit = (state == ALERT) ? DW'(ALERT_TICKS - 1) : DW'(ROTATE_TICKS - 1);
    expire      = tick && (dwell == dwell_limit);
    accept      = alert_valid && alert_ready && (state != ALERT);
    transition  = accept || expire;
    next_state  = state;
    if (accept) begin
      next_state = ALERT;
    end else if (expire) begin
      case (state)
        SHOW_A:  next_state = SHOW_B;
        SHOW_B:  next_state = SHOW_A;
        default: next_state = saved_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || transition) begin
      dwell <= '0;
    end else if (tick) begin
      dwell <= dwell + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SHOW_A;
      saved_state <= SHOW_A;
      alert_latch <= '0;
      alert_ready <= 1'b0;
    end else begin
      state       <= next_state;
      alert_ready <= (next_state != ALERT);
      if (accept) begin
        saved_state <= state;
        alert_latch <= alert_code;
      end
    end
  end

  // Outputs follow the state in effect one cycle later; background inputs stay live.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_8421_code <= '0;
      active_src    <= ACTIVE_SRC_A;
    end else begin
      case (state)
        SHOW_A: begin
          seg_8421_code <= src_a_code;
          active_src    <= ACTIVE_SRC_A;
        end
        SHOW_B: begin
          seg_8421_code <= src_b_code;
          active_src    <= ACTIVE_SRC_B;
        end
        default: begin
`ifdef SEG_BLINK_EN
          seg_8421_code <= dwell[0] ? BLANK_CODE : alert_latch;
`else
          seg_8421_code <= alert_latch;
`endif
          active_src    <= ACTIVE_SRC_ALERT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Self-checking bench for seg_display_scheduler: cycle-level schedule model plus directed literals.
// Honours SEG_BLINK_EN (alert dwell is lengthened to 4 ticks in that build).
module tb_seg_display_scheduler;

  localparam int TD = 4;
  localparam int RT = 2;
`ifdef SEG_BLINK_EN
  localparam int AT    = 4;
  localparam bit BLINK = 1'b1;
`else
  localparam int AT    = 3;
  localparam bit BLINK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] src_a_code;
  logic [15:0] src_b_code;
  logic        alert_valid;
  logic [15:0] alert_code;
  logic        alert_ready;
  logic [15:0] seg_8421_code;
  logic [1:0]  active_src;

  int n_compared   = 0;
  int n_mismatched = 0;

  seg_display_scheduler #(
    .TICK_DIV     (TD),
    .ROTATE_TICKS (RT),
    .ALERT_TICKS  (AT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .src_a_code    (src_a_code),
    .src_b_code    (src_b_code),
    .alert_valid   (alert_valid),
    .alert_code    (alert_code),
    .alert_ready   (alert_ready),
    .seg_8421_code (seg_8421_code),
    .active_src    (active_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Schedule model: which source is on screen and how many cycles it has been there.
  int          m_cur;
  int          m_saved;
  int          m_elapsed;
  logic [15:0] m_latch;
  bit          m_live = 1'b0;
  logic [15:0] e_code;
  logic [1:0]  e_src;
  logic        e_ready;
  int          resid;
  bit          accepted;

  always @(posedge clk) begin
    if (rst) begin
      m_cur     = 0;
      m_saved   = 0;
      m_elapsed = 0;
      m_latch   = 16'h0000;
      e_code    = 16'h0000;
      e_src     = 2'd0;
      e_ready   = 1'b0;
      m_live    = 1'b1;
    end else if (m_live) begin
      if (m_cur == 0) e_code = src_a_code;
      else if (m_cur == 1) e_code = src_b_code;
      else if (BLINK && ((m_elapsed / TD) % 2 == 1)) e_code = 16'hFFFF;
      else e_code = m_latch;
      e_src = 2'(m_cur);
      resid    = (m_cur == 2) ? AT * TD : RT * TD;
      accepted = alert_valid && e_ready;
      if (accepted) begin
        m_saved   = m_cur;
        m_latch   = alert_code;
        m_cur     = 2;
        m_elapsed = 0;
      end else if (m_elapsed == resid - 1) begin
        m_cur     = (m_cur == 2) ? m_saved : 1 - m_cur;
        m_elapsed = 0;
      end else begin
        m_elapsed = m_elapsed + 1;
      end
      e_ready = (m_cur != 2);
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      n_compared = n_compared + 3;
      if (seg_8421_code !== e_code) begin
        n_mismatched++;
        $display("[TB] FAIL model_code t=%0t got %h want %h", $time, seg_8421_code, e_code);
      end
      if (active_src !== e_src) begin
        n_mismatched++;
        $display("[TB] FAIL model_src t=%0t got %0d want %0d", $time, active_src, e_src);
      end
      if (alert_ready !== e_ready) begin
        n_mismatched++;
        $display("[TB] FAIL model_ready t=%0t got %0b want %0b", $time, alert_ready, e_ready);
      end
    end
  end

  task automatic apply_stimulus(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    rst         = 1'b1;
    src_a_code  = 16'h0123;
    src_b_code  = 16'h0099;
    alert_valid = 1'b0;
    alert_code  = 16'h0000;

    // Reset and rotation
    apply_stimulus(3);
    check_output("reset_code", seg_8421_code, 16'h0000);
    check_output("reset_ready", 16'(alert_ready), 16'h0000);
    check_output("reset_src", 16'(active_src), 16'h0000);
    rst = 1'b0;
    apply_stimulus(1);
    check_output("first_a_code", seg_8421_code, 16'h0123);
    check_output("first_ready", 16'(alert_ready), 16'h0001);
    apply_stimulus(7);
    check_output("last_a_src", 16'(active_src), 16'h0000);
    apply_stimulus(1);
    check_output("first_b_code", seg_8421_code, 16'h0099);
    check_output("first_b_src", 16'(active_src), 16'h0001);

    // Alert three cycles into SHOW_B
    apply_stimulus(2);
    alert_valid = 1'b1;
    alert_code  = 16'h1234;
    apply_stimulus(1);
    alert_valid = 1'b0;
    check_output("alert_ready_fall", 16'(alert_ready), 16'h0000);
    apply_stimulus(1);
    check_output("alert_code_1234", seg_8421_code, 16'h1234);
    check_output("alert_src", 16'(active_src), 16'h0002);
    apply_stimulus(AT * TD);
    check_output("resume_b_src", 16'(active_src), 16'h0001);
    check_output("resume_b_code", seg_8421_code, 16'h0099);
    apply_stimulus(7);
    check_output("resume_b_full_dwell", 16'(active_src), 16'h0001);
    apply_stimulus(1);
    check_output("after_b_src", 16'(active_src), 16'h0000);

    // Valid held through an alert is only taken once ready returns
    alert_valid = 1'b1;
    alert_code  = 16'h1111;
    apply_stimulus(1);
    alert_code  = 16'h5678;
    apply_stimulus(3);
    check_output("held_valid_ignored", 16'(alert_ready), 16'h0000);
    for (int i = 0; i < 100 && !alert_ready; i++) apply_stimulus(1);
    check_output("ready_returns", 16'(alert_ready), 16'h0001);
    apply_stimulus(1);
    alert_valid = 1'b0;
    check_output("second_accept", 16'(alert_ready), 16'h0000);
    apply_stimulus(1);
    check_output("alert_code_5678", seg_8421_code, 16'h5678);
    apply_stimulus(AT * TD);

    // Alert on the final SHOW_A cycle resumes SHOW_A
    rst = 1'b1;
    apply_stimulus(2);
    rst = 1'b0;
    apply_stimulus(7);
    alert_valid = 1'b1;
    alert_code  = 16'h9876;
    apply_stimulus(1);
    alert_valid = 1'b0;
    check_output("edge_accept_ready", 16'(alert_ready), 16'h0000);
    apply_stimulus(1);
    check_output("edge_alert_code", seg_8421_code, 16'h9876);
    apply_stimulus(AT * TD);
    check_output("edge_resume_a_src", 16'(active_src), 16'h0000);
    check_output("edge_resume_a_code", seg_8421_code, 16'h0123);

    // Reset in the middle of an alert
    alert_valid = 1'b1;
    alert_code  = 16'h2222;
    apply_stimulus(1);
    alert_valid = 1'b0;
    apply_stimulus(3);
    rst = 1'b1;
    apply_stimulus(1);
    check_output("midreset_code", seg_8421_code, 16'h0000);
    check_output("midreset_ready", 16'(alert_ready), 16'h0000);
    rst = 1'b0;
    apply_stimulus(1);
    check_output("postreset_code", seg_8421_code, 16'h0123);
    check_output("postreset_src", 16'(active_src), 16'h0000);
    src_a_code = 16'h0456;
    apply_stimulus(1);
    check_output("live_a_update", seg_8421_code, 16'h0456);

    apply_stimulus(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
